reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the out-of-order core.
- Dispatch allocates entries in program order, and execution units write results back by tag.
- The commit stage reads the oldest entry and retires it to the ARF once that entry is complete.
- Provides one operand-lookup read port, used by decode/rename for forwarding.

Parameters:
DATA_WIDTH, 32, result data width
REG_ADDR_WIDTH, 5, architectural register index width
ROB_DEPTH, 8, number of entries (power of two)
TAG_WIDTH, 3, log2(ROB_DEPTH), entry index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alloc_valid_i  input  1  dispatch requests an entry
alloc_rd_i  input  REG_ADDR_WIDTH  destination architectural register
alloc_wen_i  input  1  instruction writes rd
alloc_ready_o  output  1  buffer not full
alloc_tag_o  output  TAG_WIDTH  tag granted to the current allocation (tail index)
wb_valid_i  input  1  execution result valid
wb_tag_i  input  TAG_WIDTH  entry being completed
wb_data_i  input  DATA_WIDTH  result value
head_valid_o  output  1  head entry allocated and done
head_tag_o  output  TAG_WIDTH  head index
head_rd_o  output  REG_ADDR_WIDTH  head destination register
head_wen_o  output  1  head writes ARF
head_data_o  output  DATA_WIDTH  head result
commit_i  input  1  commit stage retires the head this cycle
flush_i  input  1  discard all entries
rd_tag_i  input  TAG_WIDTH  operand lookup tag
rd_ready_o  output  1  looked-up entry holds a valid result
rd_data_o  output  DATA_WIDTH  looked-up result
count_o  output  TAG_WIDTH+1  occupied entries

Behaviour:
- Reset (rst_n low, asynchronous):
  - head and tail pointers are 0; all valid and done bits are 0.
  - alloc_ready_o=1, alloc_tag_o=0, head_valid_o=0, count_o=0, rd_ready_o=0.
  - head_*/rd_data_o outputs read 0.
  - Reset mid-operation discards all entries.
- Per-entry state: valid, done, rd, wen, data.
- Pointers are TAG_WIDTH+1 bits, with the MSB as a wrap bit.
  - Empty: head==tail.
  - Full: indices equal and wrap bits differ.
  - count_o = tail-head, modulo 2^(TAG_WIDTH+1).
- Allocation:
  - Fires when alloc_valid_i && alloc_ready_o.
  - alloc_ready_o = !full. It does not depend on same-cycle commit.
  - On fire, the entry at tail gets valid=1, done=0, rd/wen captured, and tail increments with wrap.
  - alloc_tag_o = tail index, combinational.
- Writeback:
  - When wb_valid_i and entry[wb_tag_i].valid, set done=1 and data=wb_data_i.
  - Writeback to an invalid entry is ignored.
  - Rewriting a done entry overwrites its data.
- Head outputs:
  - Combinational from entry[head].
  - head_valid_o = valid && done.
  - A writeback to the head entry raises head_valid_o in the following cycle; there is no same-cycle bypass.
- Commit:
  - Fires when commit_i && head_valid_o. It clears entry[head].valid and increments head.
  - commit_i while head_valid_o=0 is ignored.
- Simultaneous events:
  - Allocate and commit in the same cycle: both occur, count unchanged.
  - Allocate and writeback to different entries: both occur.
  - When full, alloc_ready_o is 0, so a same-cycle commit frees a slot visible next cycle only.
- Flush:
  - Highest priority. Same-cycle alloc/wb/commit are ignored.
  - Next cycle: head=tail=0, all valid=0, count_o=0.
- Lookup:
  - rd_ready_o = entry[rd_tag_i].valid && done, with rd_data_o from that entry.
  - Same-cycle forward: if wb_valid_i && wb_tag_i==rd_tag_i && the entry is valid, then rd_ready_o=1 and rd_data_o=wb_data_i.
  - rd_ready_o=0 implies rd_data_o is don't-care; drive 0.

Test Plan:
- Reset, allocate 3 entries (rd=1,2,3, wen=1) -> alloc_tag_o 0,1,2 on successive cycles; count_o=3; head_valid_o=0.
- Writeback tag1 data 0xAAAA, then tag0 data 0x1234 -> head_valid_o rises the cycle after the tag0 write; head_rd_o=1, head_data_o=0x1234. Commit twice back-to-back -> second commit retires rd=2 data 0xAAAA; count_o=1.
- Allocate 8 entries with no commit -> alloc_ready_o=0, count_o=8, and a 9th alloc_valid_i is ignored. Complete and commit head -> alloc_ready_o=1 next cycle; next allocation gets tag 0 via wrap.
- Full buffer, head done: assert commit_i and alloc_valid_i together -> commit fires, allocation refused, count_o=7.
- Lookup tag 4 (allocated, not done) while wb tag 4 data 0xBEEF in the same cycle -> rd_ready_o=1, rd_data_o=0xBEEF; next cycle, without writeback, still 0xBEEF.
- 5 entries occupied plus same-cycle flush_i, alloc, and commit -> next cycle count_o=0, head_valid_o=0, alloc_tag_o=0. Also assert rst_n low mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at the tail, out-of-order
// completion by tag, in-order retirement from the head, plus one operand
// lookup port with same-cycle writeback forwarding.
module reorder_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ROB_DEPTH      = 8,
    parameter int TAG_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_rd_i,
    input  logic                      alloc_wen_i,
    output logic                      alloc_ready_o,
    output logic [TAG_WIDTH-1:0]      alloc_tag_o,
    input  logic                      wb_valid_i,
    input  logic [TAG_WIDTH-1:0]      wb_tag_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic                      head_valid_o,
    output logic [TAG_WIDTH-1:0]      head_tag_o,
    output logic [REG_ADDR_WIDTH-1:0] head_rd_o,
    output logic                      head_wen_o,
    output logic [DATA_WIDTH-1:0]     head_data_o,
    input  logic                      commit_i,
    input  logic                      flush_i,
    input  logic [TAG_WIDTH-1:0]      rd_tag_i,
    output logic                      rd_ready_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic [TAG_WIDTH:0]        count_o
);

    localparam int PTR_W = TAG_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [ROB_DEPTH-1:0]      r_valid;
    logic [ROB_DEPTH-1:0]      r_done;
    logic [ROB_DEPTH-1:0]      r_wen;
    logic [REG_ADDR_WIDTH-1:0] r_rd   [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     r_data [ROB_DEPTH];

    logic [TAG_WIDTH-1:0] w_headIdx;
    logic [TAG_WIDTH-1:0] w_tailIdx;
    logic                 w_full;
    logic                 w_allocFire;
    logic                 w_wbFire;
    logic                 w_commitFire;

    assign w_headIdx    = r_head[TAG_WIDTH-1:0];
    assign w_tailIdx    = r_tail[TAG_WIDTH-1:0];
    assign w_full       = (w_headIdx == w_tailIdx) && (r_head[TAG_WIDTH] != r_tail[TAG_WIDTH]);
    assign w_allocFire  = alloc_valid_i && !w_full;
    assign w_wbFire     = wb_valid_i && r_valid[wb_tag_i];
    assign w_commitFire = commit_i && head_valid_o;

    assign alloc_ready_o = !w_full;
    assign alloc_tag_o   = w_tailIdx;
    assign count_o       = r_tail - r_head;

    assign head_valid_o = r_valid[w_headIdx] && r_done[w_headIdx];
    assign head_tag_o   = w_headIdx;
    assign head_rd_o    = r_rd[w_headIdx];
    assign head_wen_o   = r_wen[w_headIdx];
    assign head_data_o  = r_data[w_headIdx];

    // Entry and pointer updates; flush overrides every other same-cycle event.
    // Alloc only touches an invalid slot and writeback only a valid one, so
    // they never collide; commit is applied last so a retiring slot ends clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_wen   <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (w_wbFire) begin
                r_done[wb_tag_i] <= 1'b1;
                r_data[wb_tag_i] <= wb_data_i;
            end
            if (w_allocFire) begin
                r_valid[w_tailIdx] <= 1'b1;
                r_done[w_tailIdx]  <= 1'b0;
                r_rd[w_tailIdx]    <= alloc_rd_i;
                r_wen[w_tailIdx]   <= alloc_wen_i;
                r_tail             <= r_tail + PTR_ONE;
            end
            if (w_commitFire) begin
                r_valid[w_headIdx] <= 1'b0;
                r_done[w_headIdx]  <= 1'b0;
                r_head             <= r_head + PTR_ONE;
            end
        end
    end

    // Operand lookup, forwarding a same-cycle writeback to the looked-up entry.
    always_comb begin
        rd_ready_o = 1'b0;
        rd_data_o  = '0;
        if (wb_valid_i && (wb_tag_i == rd_tag_i) && r_valid[rd_tag_i]) begin
            rd_ready_o = 1'b1;
            rd_data_o  = wb_data_i;
        end else if (r_valid[rd_tag_i] && r_done[rd_tag_i]) begin
            rd_ready_o = 1'b1;
            rd_data_o  = r_data[rd_tag_i];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all compared against a program-order queue model.
module tb_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid_i;
    logic [4:0]  alloc_rd_i;
    logic        alloc_wen_i;
    logic        alloc_ready_o;
    logic [2:0]  alloc_tag_o;
    logic        wb_valid_i;
    logic [2:0]  wb_tag_i;
    logic [31:0] wb_data_i;
    logic        head_valid_o;
    logic [2:0]  head_tag_o;
    logic [4:0]  head_rd_o;
    logic        head_wen_o;
    logic [31:0] head_data_o;
    logic        commit_i;
    logic        flush_i;
    logic [2:0]  rd_tag_i;
    logic        rd_ready_o;
    logic [31:0] rd_data_o;
    logic [3:0]  count_o;

    reorder_buffer #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ROB_DEPTH(8), .TAG_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i), .alloc_wen_i(alloc_wen_i),
        .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
        .head_valid_o(head_valid_o), .head_tag_o(head_tag_o), .head_rd_o(head_rd_o),
        .head_wen_o(head_wen_o), .head_data_o(head_data_o),
        .commit_i(commit_i), .flush_i(flush_i),
        .rd_tag_i(rd_tag_i), .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: instructions in program order, oldest first.
    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic        done;
        logic [31:0] data;
    } entry_t;

    entry_t modelQ[$];
    int     headTag;
    int     errors;
    int     checks;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int slotOf(input logic [2:0] tag);
        return (int'(tag) - headTag + 8) % 8;
    endfunction

    // Compare every output against the model for the inputs currently driven.
    task automatic checkAll();
        int     size;
        int     idx;
        logic   inQ;
        logic   fwd;
        logic   expReady;
        logic [31:0] expData;
        logic   expHeadValid;
        size = modelQ.size();
        expHeadValid = (size > 0) && modelQ[0].done;
        checkOutput("alloc_ready", 32'(alloc_ready_o), 32'(size < 8));
        checkOutput("alloc_tag", 32'(alloc_tag_o), 32'((headTag + size) % 8));
        checkOutput("count", 32'(count_o), 32'(size));
        checkOutput("head_tag", 32'(head_tag_o), 32'(headTag));
        checkOutput("head_valid", 32'(head_valid_o), 32'(expHeadValid));
        if (expHeadValid) begin
            checkOutput("head_rd", 32'(head_rd_o), 32'(modelQ[0].rd));
            checkOutput("head_wen", 32'(head_wen_o), 32'(modelQ[0].wen));
            checkOutput("head_data", head_data_o, modelQ[0].data);
        end
        idx = slotOf(rd_tag_i);
        inQ = idx < size;
        fwd = wb_valid_i && (wb_tag_i == rd_tag_i) && inQ;
        expReady = fwd || (inQ && modelQ[idx].done);
        expData = fwd ? wb_data_i : (expReady ? modelQ[idx].data : 32'h0);
        checkOutput("rd_ready", 32'(rd_ready_o), 32'(expReady));
        checkOutput("rd_data", rd_data_o, expData);
    endtask

    // Advance the model by one clock using the pre-edge state and inputs.
    task automatic updateModel();
        int     size;
        int     idx;
        logic   hv;
        entry_t e;
        size = modelQ.size();
        if (flush_i) begin
            modelQ.delete();
            headTag = 0;
            return;
        end
        hv = (size > 0) && modelQ[0].done;
        if (wb_valid_i) begin
            idx = slotOf(wb_tag_i);
            if (idx < size) begin
                e = modelQ[idx];
                e.done = 1'b1;
                e.data = wb_data_i;
                modelQ[idx] = e;
            end
        end
        if (commit_i && hv) begin
            void'(modelQ.pop_front());
            headTag = (headTag + 1) % 8;
        end
        if (alloc_valid_i && (size < 8)) begin
            e.rd = alloc_rd_i;
            e.wen = alloc_wen_i;
            e.done = 1'b0;
            e.data = 32'h0;
            modelQ.push_back(e);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), check, then clock it.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic awen,
                                 input logic wv, input logic [2:0] wtag, input logic [31:0] wdata,
                                 input logic cm, input logic fl, input logic [2:0] rtag);
        alloc_valid_i = av;
        alloc_rd_i    = ard;
        alloc_wen_i   = awen;
        wb_valid_i    = wv;
        wb_tag_i      = wtag;
        wb_data_i     = wdata;
        commit_i      = cm;
        flush_i       = fl;
        rd_tag_i      = rtag;
        #1;
        checkAll();
        updateModel();
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic [2:0] rtag);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, rtag);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_alloc_ready"}, 32'(alloc_ready_o), 32'd1);
        checkOutput({pfx, "_alloc_tag"}, 32'(alloc_tag_o), 32'd0);
        checkOutput({pfx, "_head_valid"}, 32'(head_valid_o), 32'd0);
        checkOutput({pfx, "_count"}, 32'(count_o), 32'd0);
        checkOutput({pfx, "_rd_ready"}, 32'(rd_ready_o), 32'd0);
        checkOutput({pfx, "_rd_data"}, rd_data_o, 32'd0);
        checkOutput({pfx, "_head_rd"}, 32'(head_rd_o), 32'd0);
        checkOutput({pfx, "_head_data"}, head_data_o, 32'd0);
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), 1'($urandom),
                          $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                          3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        headTag = 0;
        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_rd_i = '0; alloc_wen_i = 1'b0;
        wb_valid_i = 1'b0; wb_tag_i = '0; wb_data_i = '0;
        commit_i = 1'b0; flush_i = 1'b0; rd_tag_i = '0;
        #1;
        checkResetValues("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Three allocations in program order, then out-of-order completion.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 5'(i + 1), 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        checkOutput("tp1_count", 32'(count_o), 32'd3);
        checkOutput("tp1_head_valid", 32'(head_valid_o), 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 32'hAAAA, 1'b0, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h1234, 1'b0, 1'b0, 3'd0);
        checkOutput("tp2_head_valid", 32'(head_valid_o), 32'd1);
        checkOutput("tp2_head_rd", 32'(head_rd_o), 32'd1);
        checkOutput("tp2_head_data", head_data_o, 32'h1234);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 3'd0);
        checkOutput("tp2_second_rd", 32'(head_rd_o), 32'd2);
        checkOutput("tp2_second_data", head_data_o, 32'hAAAA);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 3'd0);
        checkOutput("tp2_count", 32'(count_o), 32'd1);

        // Fill to capacity, refuse a ninth, then commit+alloc while full.
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 5'(i + 8), 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        checkOutput("tp3_full_ready", 32'(alloc_ready_o), 32'd0);
        checkOutput("tp3_full_count", 32'(count_o), 32'd8);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h55, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 5'd30, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 3'd0);
        checkOutput("tp4_count", 32'(count_o), 32'd7);
        checkOutput("tp4_ready", 32'(alloc_ready_o), 32'd1);
        checkOutput("tp4_wrap_tag", 32'(alloc_tag_o), 32'd0);
        applyStimulus(1'b1, 5'd31, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0);

        // Lookup forwarding on tag 4, then the stored value on the next cycle.
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd4, 32'hBEEF, 1'b0, 1'b0, 3'd4);
        idleCycle(3'd4);
        checkOutput("tp5_rd_ready", 32'(rd_ready_o), 32'd1);
        checkOutput("tp5_rd_data", rd_data_o, 32'hBEEF);

        // Flush wins over a same-cycle alloc and commit.
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 5'(i), 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h77, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 3'd0);
        checkOutput("tp6_count", 32'(count_o), 32'd0);
        checkOutput("tp6_head_valid", 32'(head_valid_o), 32'd0);
        checkOutput("tp6_alloc_tag", 32'(alloc_tag_o), 32'd0);

        randomCycles(1500);

        // Asynchronous reset mid-stream, checked before any clock edge.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 5'(i), 1'b1, 1'b1, 3'(i), 32'(i + 100), 1'b0, 1'b0, 3'd0);
        #2;
        alloc_valid_i = 1'b0; wb_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetValues("async");
        modelQ.delete();
        headTag = 0;
        @(negedge clk);
        rst_n = 1'b1;

        randomCycles(1500);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
